// File: rtl/mac_avg_window.sv
// Multiply-accumulate window averager: emits the truncated mean of N = 2^LOG2_N
// products, either once per window (MODE 0) or sliding on every sample (MODE 1).
module mac_avg_window #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned LOG2_N = 2,
   parameter int unsigned MODE   = 0
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  Clear,
   input  logic                  In_valid,
   output logic                  In_ready,
   input  logic [DATA_W-1:0]     DataIn1,
   input  logic [DATA_W-1:0]     DataIn2,
   output logic                  Out_valid,
   input  logic                  Out_ready,
   output logic [2*DATA_W-1:0]   AverageOut,
   output logic                  Full,
   output logic [LOG2_N:0]       Count
);

   localparam int unsigned N  = 1 << LOG2_N;
   localparam int unsigned PW = 2 * DATA_W;
   localparam int unsigned SW = PW + LOG2_N;
   localparam int unsigned CW = LOG2_N + 1;

   typedef enum logic {ST_FILL, ST_STEADY} state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   sum_q, sum_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   hist_q [N];
   logic [PW-1:0]   hist_d [N];
   logic [PW-1:0]   avg_q, avg_d;
   logic            out_valid_q, out_valid_d;

   logic [PW-1:0]   product_c;
   logic            completes_c;
   logic            accept_c;
   logic [SW-1:0]   sum_add_c;
   logic [SW-1:0]   sum_slide_c;

   // Handshake and arithmetic for the sample presented this cycle
   always_comb begin
      product_c   = PW'(DataIn1) * PW'(DataIn2);
      completes_c = (MODE == 0) ? (count_q == CW'(N - 1)) : (count_q >= CW'(N - 1));
      In_ready    = !(out_valid_q && !Out_ready && completes_c);
      accept_c    = In_valid && In_ready;
      sum_add_c   = sum_q + SW'(product_c);
      // The oldest history slot is zero until the window has filled once
      sum_slide_c = sum_add_c - SW'(hist_q[N-1]);
   end

   // Next-state logic; Clear overrides every other update
   always_comb begin
      state_d     = state_q;
      sum_d       = sum_q;
      count_d     = count_q;
      hist_d      = hist_q;
      avg_d       = avg_q;
      out_valid_d = out_valid_q;

      if (Out_ready) begin
         out_valid_d = 1'b0;
      end

      if (Clear) begin
         state_d     = ST_FILL;
         sum_d       = '0;
         count_d     = '0;
         avg_d       = '0;
         out_valid_d = 1'b0;
         for (int unsigned i = 0; i < N; i++) begin
            hist_d[i] = '0;
         end
      end else if (accept_c) begin
         if (MODE == 0) begin
            if (completes_c) begin
               avg_d       = PW'(sum_add_c >> LOG2_N);
               out_valid_d = 1'b1;
               sum_d       = '0;
               count_d     = '0;
            end else begin
               sum_d   = sum_add_c;
               count_d = count_q + CW'(1);
            end
         end else begin
            hist_d[0] = product_c;
            for (int unsigned i = 1; i < N; i++) begin
               hist_d[i] = hist_q[i-1];
            end
            sum_d = sum_slide_c;
            if (state_q == ST_FILL) begin
               count_d = count_q + CW'(1);
               if (count_q == CW'(N - 1)) begin
                  state_d = ST_STEADY;
               end
            end
            if (completes_c) begin
               avg_d       = PW'(sum_slide_c >> LOG2_N);
               out_valid_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= ST_FILL;
         sum_q       <= '0;
         count_q     <= '0;
         avg_q       <= '0;
         out_valid_q <= 1'b0;
         for (int unsigned i = 0; i < N; i++) begin
            hist_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         sum_q       <= sum_d;
         count_q     <= count_d;
         avg_q       <= avg_d;
         out_valid_q <= out_valid_d;
         for (int unsigned i = 0; i < N; i++) begin
            hist_q[i] <= hist_d[i];
         end
      end
   end

   assign Out_valid  = out_valid_q;
   assign AverageOut = avg_q;
   assign Count      = count_q;
   assign Full       = out_valid_q && !Out_ready;

endmodule

// File: tb/tb_mac_avg_window.sv
// Bench for mac_avg_window: one block-mode and one sliding-mode instance, a result
// scoreboard per instance, a window table, and hand-written corner sequences.
module tb_mac_avg_window;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;

   logic       clr0 = 1'b0, v0 = 1'b0, or0 = 1'b1;
   logic [3:0] a0 = '0, b0 = '0;
   logic       rdy0, ov0, full0;
   logic [7:0] avg0;
   logic [2:0] cnt0;

   logic       clr1 = 1'b0, v1 = 1'b0, or1 = 1'b1;
   logic [3:0] a1 = '0, b1 = '0;
   logic       rdy1, ov1, full1;
   logic [7:0] avg1;
   logic [2:0] cnt1;

   int n_cmp = 0;
   int n_err = 0;
   int q0[$];
   int q1[$];
   int m1[$];

   always #5 Clk = ~Clk;

   mac_avg_window #(.DATA_W(4), .LOG2_N(2), .MODE(0)) u_blk (
      .Clk(Clk), .Reset_n(Reset_n), .Clear(clr0), .In_valid(v0), .In_ready(rdy0),
      .DataIn1(a0), .DataIn2(b0), .Out_valid(ov0), .Out_ready(or0),
      .AverageOut(avg0), .Full(full0), .Count(cnt0));

   mac_avg_window #(.DATA_W(4), .LOG2_N(2), .MODE(1)) u_sld (
      .Clk(Clk), .Reset_n(Reset_n), .Clear(clr1), .In_valid(v1), .In_ready(rdy1),
      .DataIn1(a1), .DataIn2(b1), .Out_valid(ov1), .Out_ready(or1),
      .AverageOut(avg1), .Full(full1), .Count(cnt1));

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scoreboards: a result is consumed at the edge following a valid&&ready cycle
   always @(negedge Clk) begin
      if (Reset_n) begin
         check("full0", int'(full0), int'(ov0 && !or0));
         check("full1", int'(full1), int'(ov1 && !or1));
         if (ov0 && or0) begin
            if (q0.size() == 0) check("blk_unexpected_result", int'(avg0), -1);
            else check("blk_result", int'(avg0), q0.pop_front());
         end
         if (ov1 && or1) begin
            if (q1.size() == 0) check("sld_unexpected_result", int'(avg1), -1);
            else check("sld_result", int'(avg1), q1.pop_front());
         end
      end
   end

   task automatic send0(input logic [3:0] a, input logic [3:0] b);
      logic r;
      v0 = 1'b1; a0 = a; b0 = b;
      for (int i = 0; i < 20; i++) begin
         @(negedge Clk); r = rdy0;
         @(posedge Clk); #1;
         if (r) begin
            v0 = 1'b0;
            return;
         end
      end
      check("blk_send_timeout", 0, 1);
      v0 = 1'b0;
   endtask

   // Sliding reference model: keep the last four products, predict each full-window mean
   task automatic send1(input logic [3:0] a, input logic [3:0] b);
      logic r;
      int   s;
      m1.push_back(int'(a) * int'(b));
      if (m1.size() > 4) void'(m1.pop_front());
      if (m1.size() == 4) begin
         s = 0;
         foreach (m1[k]) s += m1[k];
         q1.push_back(s / 4);
      end
      v1 = 1'b1; a1 = a; b1 = b;
      for (int i = 0; i < 20; i++) begin
         @(negedge Clk); r = rdy1;
         @(posedge Clk); #1;
         if (r) begin
            v1 = 1'b0;
            return;
         end
         if (i >= 2) or1 = 1'b1;
      end
      check("sld_send_timeout", 0, 1);
      v1 = 1'b0;
   endtask

   typedef struct packed {
      logic [3:0][3:0] a;
      logic [3:0][3:0] b;
      logic [7:0]      avg;
   } vec_t;

   vec_t vecs [4];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{a: {4'd15, 4'd15, 4'd15, 4'd15}, b: {4'd15, 4'd15, 4'd15, 4'd15}, avg: 8'd225};
      vecs[1] = '{a: {4'd0, 4'd0, 4'd0, 4'd0},     b: {4'd9, 4'd3, 4'd15, 4'd7},    avg: 8'd0};
      vecs[2] = '{a: {4'd5, 4'd6, 4'd7, 4'd8},     b: {4'd3, 4'd1, 4'd2, 4'd9},     avg: 8'd26};
      vecs[3] = '{a: {4'd8, 4'd8, 4'd8, 4'd7},     b: {4'd8, 4'd8, 4'd8, 4'd9},     avg: 8'd63};

      // Reset state
      #3;
      check("rst_ov0", int'(ov0), 0);
      check("rst_avg0", int'(avg0), 0);
      check("rst_cnt0", int'(cnt0), 0);
      check("rst_cnt1", int'(cnt1), 0);
      #9 Reset_n = 1'b1;
      @(posedge Clk); #1;
      check("rst_rdy0", int'(rdy0), 1);
      check("rst_rdy1", int'(rdy1), 1);

      // Block mode: one window of 1,4,9,16
      q0.push_back(7);
      for (int i = 1; i <= 4; i++) send0(4'(i), 4'(i));
      check("t1_ov", int'(ov0), 1);
      check("t1_avg", int'(avg0), 7);
      check("t1_cnt", int'(cnt0), 0);
      @(posedge Clk); #1;
      check("t1_ov_drop", int'(ov0), 0);

      // Block mode window table
      for (int r = 0; r < 4; r++) begin
         q0.push_back(int'(vecs[r].avg));
         for (int j = 0; j < 4; j++) send0(vecs[r].a[j], vecs[r].b[j]);
         check("tbl_ov", int'(ov0), 1);
         check("tbl_avg", int'(avg0), int'(vecs[r].avg));
         check("tbl_cnt", int'(cnt0), 0);
      end

      // Sliding mode: products 4,8,12,16,20
      for (int i = 1; i <= 3; i++) begin
         send1(4'(i), 4'd4);
         check("t3_fill_ov", int'(ov1), 0);
         check("t3_fill_cnt", int'(cnt1), i);
      end
      send1(4'd4, 4'd4);
      check("t3_ov4", int'(ov1), 1);
      check("t3_avg4", int'(avg1), 10);
      check("t3_cnt4", int'(cnt1), 4);
      send1(4'd5, 4'd4);
      check("t3_avg5", int'(avg1), 14);
      check("t3_cnt5", int'(cnt1), 4);

      // Sliding mode with random samples and random back-pressure
      for (int i = 0; i < 16; i++) begin
         or1 = 1'($urandom_range(0, 1));
         send1(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         check("rnd_cnt1", int'(cnt1), 4);
      end
      or1 = 1'b1;
      @(posedge Clk); #1;

      // Block mode back-pressure: result pending while the next window fills
      or0 = 1'b0;
      q0.push_back(7);
      for (int i = 1; i <= 4; i++) send0(4'(i), 4'(i));
      q0.push_back(4);
      for (int i = 0; i < 3; i++) send0(4'd2, 4'd2);
      check("t4_hold_avg", int'(avg0), 7);
      check("t4_hold_cnt", int'(cnt0), 3);
      v0 = 1'b1; a0 = 4'd2; b0 = 4'd2;
      @(negedge Clk);
      check("t4_stall_rdy", int'(rdy0), 0);
      check("t4_stall_full", int'(full0), 1);
      @(posedge Clk); #1;
      check("t4_stall_cnt", int'(cnt0), 3);
      check("t4_stall_ov", int'(ov0), 1);
      or0 = 1'b1;
      @(negedge Clk);
      check("t4_release_rdy", int'(rdy0), 1);
      @(posedge Clk); #1;
      v0 = 1'b0;
      check("t4_ov_cont", int'(ov0), 1);
      check("t4_avg_next", int'(avg0), 4);
      check("t4_cnt", int'(cnt0), 0);
      @(posedge Clk); #1;

      // Clear mid-window, with a concurrent sample that must be dropped
      send0(4'd3, 4'd3);
      send0(4'd3, 4'd3);
      v0 = 1'b1; a0 = 4'd3; b0 = 4'd3; clr0 = 1'b1;
      @(posedge Clk); #1;
      v0 = 1'b0; clr0 = 1'b0;
      check("t5_cnt", int'(cnt0), 0);
      check("t5_ov", int'(ov0), 0);
      check("t5_avg", int'(avg0), 0);
      q0.push_back(4);
      for (int i = 0; i < 4; i++) send0(4'd2, 4'd2);
      check("t5_avg_after", int'(avg0), 4);

      // Asynchronous reset while a result is pending
      @(posedge Clk); #1;
      or0 = 1'b0;
      for (int i = 1; i <= 4; i++) send0(4'(i), 4'(i));
      check("t6_pend_ov", int'(ov0), 1);
      check("t6_pend_avg", int'(avg0), 7);
      #3 Reset_n = 1'b0;
      #1;
      check("t6_rst_ov", int'(ov0), 0);
      check("t6_rst_avg", int'(avg0), 0);
      check("t6_rst_cnt", int'(cnt0), 0);
      m1.delete();
      #3 Reset_n = 1'b1;
      @(posedge Clk); #1;
      or0 = 1'b1;
      for (int i = 1; i <= 3; i++) send0(4'(i), 4'(i));
      check("t6_no_partial", int'(ov0), 0);
      check("t6_cnt3", int'(cnt0), 3);
      q0.push_back(7);
      send0(4'd4, 4'd4);
      check("t6_fresh_avg", int'(avg0), 7);

      repeat (4) @(posedge Clk);
      #1;
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
